// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) log/antilog table builder: field size,
// FSM states, lookup op-codes and the supported field degrees.
package gf_pkg;

    localparam int MMAX = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUILD,
        READY,
        ERROR
    } gf_state_e;

    localparam logic OP_ANTILOG = 1'b0;
    localparam logic OP_LOG     = 1'b1;

    localparam logic [2:0] DEG_MIN = 3'd3;
    localparam logic [2:0] DEG_MAX = 3'd4;

    function automatic logic deg_legal(input logic [2:0] m);
        return (m == DEG_MIN) || (m == DEG_MAX);
    endfunction

endpackage

// File: rtl/gf_table_ram.sv
// Small table memory: one synchronous write port, one registered read port.
module gf_table_ram #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1 << AW)-1];

    // NOTE: the array has no reset; every entry is rewritten by a build before
    // lookups are accepted, so resetting it would only add logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/gf_table_builder.sv
// Builds GF(2^m) log/antilog tables from an element stream and serves lookups.
// Optional macro GF_DUPCHK_EN adds a seen-vector that rejects repeated or out-of-field elements.
module gf_table_builder #(
    parameter int MMAX = gf_pkg::MMAX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      m_sel,
    input  logic            elem_valid,
    input  logic [MMAX-1:0] elem,
    input  logic            req_valid,
    input  logic            req_op,
    input  logic [MMAX-1:0] req_data,
    output logic            resp_valid,
    output logic [MMAX-1:0] resp_data,
    output logic            resp_err,
    output logic            ready,
    output logic            build_err
);

    import gf_pkg::*;

    gf_state_e       state, state_n;
    logic [2:0]      m_q;
    logic [MMAX-1:0] idx;
    logic            got_zero;
    logic            build_clr, zero_ok, store, lookup;
    logic            dup_bad;
    logic [MMAX-1:0] deg_mask, last_idx;
    logic [MMAX-1:0] log_addr, ant_addr;
    logic [MMAX-1:0] log_rdata, antilog_rdata;
    logic            resp_op_q;

    assign deg_mask = MMAX'((32'd1 << m_q) - 32'd1);
    assign last_idx = MMAX'((32'd1 << m_q) - 32'd2);

`ifdef GF_DUPCHK_EN
    logic [(1 << MMAX)-1:0] seen;

    assign dup_bad = seen[elem] || ((elem & ~deg_mask) != '0);

    always_ff @(posedge clk) begin
        if (rst || build_clr) begin
            seen <= '0;
        end else if (zero_ok || store) begin
            seen[elem] <= 1'b1;
        end
    end
`else
    assign dup_bad = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        build_clr = 1'b0;
        zero_ok   = 1'b0;
        store     = 1'b0;
        lookup    = 1'b0;
        if (start) begin
            if (deg_legal(m_sel)) begin
                state_n   = BUILD;
                build_clr = 1'b1;
            end else begin
                state_n = ERROR;
            end
        end else begin
            unique case (state)
                BUILD: begin
                    if (elem_valid) begin
                        if (!got_zero) begin
                            if (elem != '0) state_n = ERROR;
                            else            zero_ok = 1'b1;
                        end else if (dup_bad) begin
                            state_n = ERROR;
                        end else begin
                            store = 1'b1;
                            if (idx == last_idx) state_n = READY;
                        end
                    end
                end
                READY:   lookup = req_valid;
                default: ;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            got_zero <= 1'b0;
            m_q      <= DEG_MAX;
        end else if (build_clr) begin
            idx      <= '0;
            got_zero <= 1'b0;
            m_q      <= m_sel;
        end else begin
            if (zero_ok) got_zero <= 1'b1;
            if (store)   idx      <= idx + 1'b1;
        end
    end

    // Log ignores operand bits above the degree; antilog wraps the index at the group order.
    assign log_addr = req_data & deg_mask;
    assign ant_addr = (m_q == DEG_MIN) ? MMAX'(32'(req_data) % 32'd7)
                                       : MMAX'(32'(req_data) % 32'd15);

    gf_table_ram #(.AW(MMAX), .DW(MMAX)) u_antilog (
        .clk   (clk),
        .we    (store),
        .waddr (idx),
        .wdata (elem),
        .raddr (ant_addr),
        .rdata (antilog_rdata)
    );

    gf_table_ram #(.AW(MMAX), .DW(MMAX)) u_log (
        .clk   (clk),
        .we    (store),
        .waddr (elem),
        .wdata (idx),
        .raddr (log_addr),
        .rdata (log_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_op_q  <= OP_ANTILOG;
        end else begin
            resp_valid <= lookup;
            resp_err   <= lookup && (req_op == OP_LOG) && (log_addr == '0);
            resp_op_q  <= req_op;
        end
    end

    // The table read registers are unreset, so the data is gated by the reset-cleared strobe.
    assign resp_data = (!resp_valid || resp_err) ? '0
                     : (resp_op_q == OP_LOG) ? log_rdata : antilog_rdata;

    assign ready     = (state == READY);
    assign build_err = (state == ERROR);

endmodule
